// File: rtl/xnorpop_pkg.sv
// Shared constants and helpers for the xnor-popcount accumulator.
// Holds clog2, default parameters and the default per-lane count width.
package xnorpop_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEF_WIDTH = 128;
    localparam int DEF_LANES = 4;
    localparam int DEF_ACC_W = 16;

    // Lane count width for the default configuration.
    localparam int LANE_CW = clog2(DEF_WIDTH / DEF_LANES + 1);

endpackage

// File: rtl/xnorpop_lane.sv
// Combinational xnor-popcount of one operand slice.
// Ports: x, y (SW-bit slices), cnt (number of equal bit positions).
module xnorpop_lane
    import xnorpop_pkg::*;
#(
    parameter int SW = DEF_WIDTH / DEF_LANES,
    parameter int CW = LANE_CW
) (
    input  logic [SW-1:0] x,
    input  logic [SW-1:0] y,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SW; i++) begin
            cnt = cnt + CW'(x[i] ~^ y[i]);
        end
    end

endmodule

// File: rtl/xnorpop_accum_pipe.sv
// Two-stage xnor-popcount accumulator with valid/ready on both sides.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_x/in_y/in_last beat
// input; out_valid/out_ready/out_sum/out_ovf vector result.
// Macro XNORPOP_SAT_EN: saturate the accumulator instead of wrapping.
module xnorpop_accum_pipe
    import xnorpop_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int SW  = WIDTH / LANES;
    localparam int LCW = clog2(SW + 1);
    localparam int BCW = clog2(WIDTH + 1);

    logic [LANES-1:0][LCW-1:0] lane_cnt;
    logic [LANES-1:0][LCW-1:0] s1_cnt;
    logic                      s1_valid;
    logic                      s1_last;
    logic                      rdy_en;

    logic [ACC_W-1:0] acc;
    logic             acc_ovf;
    logic [BCW-1:0]   beat_sum;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic             s2_adv;
    logic             s1_take;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        xnorpop_lane #(
            .SW(SW),
            .CW(LCW)
        ) u_lane (
            .x  (in_x[g*SW +: SW]),
            .y  (in_y[g*SW +: SW]),
            .cnt(lane_cnt[g])
        );
    end

    // Only a last beat needs the output register, so only it can stall.
    assign s2_adv   = !(s1_valid && s1_last && out_valid && !out_ready);
    assign in_ready = rdy_en && (!s1_valid || s2_adv);
    assign s1_take  = in_valid && in_ready;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + BCW'(s1_cnt[i]);
        end
    end

    assign sum_ext  = {1'b0, acc} + (ACC_W+1)'(beat_sum);
    assign ovf_next = acc_ovf | sum_ext[ACC_W];

`ifdef XNORPOP_SAT_EN
    assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    // Ready is held low through reset and comes up on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cnt   <= '0;
        end else if (s1_take) begin
            s1_valid <= 1'b1;
            s1_last  <= in_last;
            s1_cnt   <= lane_cnt;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (s1_valid && s2_adv) begin
                if (s1_last) begin
                    out_valid <= 1'b1;
                    out_sum   <= acc_next;
                    out_ovf   <= ovf_next;
                    acc       <= '0;
                    acc_ovf   <= 1'b0;
                end else begin
                    acc     <= acc_next;
                    acc_ovf <= ovf_next;
                end
            end
        end
    end

endmodule
